// File: rtl/dmem_cache_responder.sv
// Data-memory responder for the MEM stage: a direct-mapped, write-through,
// no-write-allocate cache in front of a multi-cycle backing store.
module dmem_cache_responder #(
  parameter int DEPTH_WORDS  = 256,
  parameter int LINES        = 16,
  parameter int MISS_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] read_data,
  output logic        stall,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int WIDX_W = $clog2(DEPTH_WORDS);
  localparam int LINE_W = $clog2(LINES);
  localparam int TAG_W  = WIDX_W - LINE_W;
  localparam int CNT_W  = (MISS_LATENCY > 1) ? $clog2(MISS_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MISS_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    MISS_WAIT,
    WRITE_WAIT,
    RESP
  } state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDX_W-1:0] pendIdx_q, pendIdx_d;
  logic [31:0]       pendData_q, pendData_d;
  logic              respIsRead_q, respIsRead_d;
  logic [31:0]       resp_q;
  logic [15:0]       hitCnt_q, missCnt_q;

  logic [LINES-1:0]  lineValid_q;
  logic [TAG_W-1:0]  lineTag_q  [LINES];
  logic [31:0]       lineData_q [LINES];
  logic [31:0]       backing_q  [DEPTH_WORDS];

  logic [WIDX_W-1:0] wordIdx;
  logic [LINE_W-1:0] lineIdx;
  logic [TAG_W-1:0]  tagIn;
  logic [LINE_W-1:0] pendLine;
  logic [TAG_W-1:0]  pendTag;
  logic              hit;
  logic              stallRaw;
  logic [31:0]       readRaw;
  logic              hitInc;
  logic              missInc;
  logic              fillEn;
  logic              storeEn;
  logic              addrUnused;

  // Address bits above the backing-store range alias; byte offset is ignored.
  assign wordIdx    = addr[WIDX_W+1:2];
  assign lineIdx    = wordIdx[LINE_W-1:0];
  assign tagIn      = wordIdx[WIDX_W-1:LINE_W];
  assign pendLine   = pendIdx_q[LINE_W-1:0];
  assign pendTag    = pendIdx_q[WIDX_W-1:LINE_W];
  assign addrUnused = ^{addr[31:WIDX_W+2], addr[1:0]};

  assign hit = mem_read && lineValid_q[lineIdx] && (lineTag_q[lineIdx] == tagIn);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pendIdx_d    = pendIdx_q;
    pendData_d   = pendData_q;
    respIsRead_d = respIsRead_q;
    stallRaw     = 1'b0;
    readRaw      = '0;
    hitInc       = 1'b0;
    missInc      = 1'b0;
    fillEn       = 1'b0;
    storeEn      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_write) begin
          stallRaw     = 1'b1;
          pendIdx_d    = wordIdx;
          pendData_d   = write_data;
          cnt_d        = CNT_INIT;
          respIsRead_d = 1'b0;
          state_d      = WRITE_WAIT;
        end else if (mem_read) begin
          if (hit) begin
            readRaw = lineData_q[lineIdx];
            hitInc  = 1'b1;
          end else begin
            stallRaw     = 1'b1;
            pendIdx_d    = wordIdx;
            cnt_d        = CNT_INIT;
            respIsRead_d = 1'b1;
            missInc      = 1'b1;
            state_d      = MISS_WAIT;
          end
        end
      end
      MISS_WAIT: begin
        stallRaw = 1'b1;
        if (cnt_q == '0) begin
          fillEn  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WRITE_WAIT: begin
        stallRaw = 1'b1;
        if (cnt_q == '0) begin
          storeEn = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        readRaw = respIsRead_q ? resp_q : 32'h0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held, even with a request presented.
  assign stall      = stallRaw & ~reset;
  assign read_data  = reset ? 32'h0 : readRaw;
  assign hit_count  = hitCnt_q;
  assign miss_count = missCnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pendIdx_q    <= '0;
      pendData_q   <= '0;
      respIsRead_q <= 1'b0;
      resp_q       <= '0;
      lineValid_q  <= '0;
      hitCnt_q     <= '0;
      missCnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pendIdx_q    <= pendIdx_d;
      pendData_q   <= pendData_d;
      respIsRead_q <= respIsRead_d;
      if (fillEn) begin
        resp_q                <= backing_q[pendIdx_q];
        lineValid_q[pendLine] <= 1'b1;
      end
      if (hitInc && (hitCnt_q != 16'hFFFF)) begin
        hitCnt_q <= hitCnt_q + 16'd1;
      end
      if (missInc && (missCnt_q != 16'hFFFF)) begin
        missCnt_q <= missCnt_q + 16'd1;
      end
    end
  end

  // Storage arrays carry no reset; an aborted fill or store never reaches here
  // because reset forces the controller back to IDLE first.
  always_ff @(posedge clk) begin
    if (fillEn) begin
      lineTag_q[pendLine]  <= pendTag;
      lineData_q[pendLine] <= backing_q[pendIdx_q];
    end
    if (storeEn) begin
      backing_q[pendIdx_q] <= pendData_q;
      if (lineValid_q[pendLine] && (lineTag_q[pendLine] == pendTag)) begin
        lineData_q[pendLine] <= pendData_q;
      end
    end
  end

endmodule
